uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART transfer path, sitting directly downstream of the baud-rate tick generator. It samples the asynchronous `rx` line at 16x oversampling, using a one-clock enable pulse supplied by the tick generator. It decodes 8N1 frames, LSB first, and presents each received byte with a one-cycle valid strobe. Framing errors and false starts are detected and reported without corrupting the last good byte.

## Interface
- `DBIT`, 8: data bits per frame.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period. Must be even and ≥ 4.
- `SB_TICK`, 16: `s_tick` pulses from the last data-bit sample to the stop-bit sample. Must equal `OVERSAMPLE` for 1 stop bit.
- `clk` input 1: system clock. All state changes on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `rx` input 1: asynchronous serial line. Idle high.
- `s_tick` input 1: oversample enable. One `clk` wide, one pulse per 1/`OVERSAMPLE` bit time. The tick source must be configured in pulse form, not toggle form.
- `rx_data` output `DBIT`: last correctly framed byte.
- `rx_done_tick` output 1: one-cycle strobe when `rx_data` updates.
- `frame_err` output 1: one-cycle strobe on a bad stop bit.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- Internal registers:
  - `state`
  - tick counter `cnt`, width ≥ clog2(max(`OVERSAMPLE`, `SB_TICK`))
  - bit counter `n`, width clog2(`DBIT`)
  - shift register `sh`, `DBIT` bits
- `s_tick` is ignored in `IDLE` and `WAIT_IDLE`. In the other states, `cnt` advances only on `s_tick`.
- IDLE:
  - On `rx_s`==0 (sampled every clk, not tick-gated), clear `cnt` and go to START.
- START:
  - Ticks with `cnt` < `OVERSAMPLE`/2−1 increment `cnt`.
  - On the tick with `cnt`==`OVERSAMPLE`/2−1 (mid start bit):
    - if `rx_s`==0: clear `cnt` and `n`, go to DATA;
    - else: false start, go to IDLE with no output activity.
- DATA:
  - On the tick with `cnt`==`OVERSAMPLE`−1: `sh` ← {`rx_s`, `sh`[`DBIT`−1:1]} (LSB first), clear `cnt`.
  - If `n`==`DBIT`−1, go to STOP; else increment `n`.
  - Other ticks increment `cnt`.
- STOP:
  - On the tick with `cnt`==`SB_TICK`−1 (mid stop bit):
    - if `rx_s`==1: `rx_data` ← `sh`, `rx_done_tick`=1, go to IDLE;
    - else: `frame_err`=1, `rx_data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rx_s`==1, then go to IDLE. This prevents a held-low (break) line from retriggering frames.
- Returning to IDLE at mid stop bit is intentional. It allows back-to-back frames with no idle gap.
- Unreachable state encodings recover to IDLE.

## Timing
- Reset values:
  - `rx_data`=0, `rx_done_tick`=0, `frame_err`=0
  - `state`=IDLE, `cnt`=0, `n`=0, `sh`=0
  - synchronizer flops=1
- `reset` asserted mid-frame aborts immediately. No strobe is produced after release. The receiver resumes in IDLE.
- Start detection latency: 2 clk of synchronizer plus 1 clk to enter START after the `rx` falling edge.
- `rx_done_tick` and `frame_err` are registered. They assert in the clk cycle after the `s_tick` that samples the stop bit, and are high for exactly 1 clk.
- `rx_data` changes in the same cycle `rx_done_tick` rises and holds until the next good frame.
- `rx_done_tick` and `frame_err` are never asserted together.
- Sample points relative to the start-bit falling edge, in ticks:
  - start: `OVERSAMPLE`/2
  - data bit k: `OVERSAMPLE`/2 + (k+1)·`OVERSAMPLE`
  - stop: data bit `DBIT`−1 sample + `SB_TICK`
- `s_tick` coinciding with the IDLE→START transition is not counted.

## Test plan
- Basic byte:
  - Stimulus: `s_tick` every 4 clk, so 1 bit = 64 clk. Send 0xA5 as 8N1.
  - Response: `rx_data`=0xA5, single `rx_done_tick` pulse, `frame_err`=0.
- False start:
  - Stimulus: `rx` low for 3 ticks, then high.
  - Response: state returns to IDLE, no strobes, `rx_data` unchanged.
- Framing error:
  - Stimulus: send 0x5A with stop bit 0, hold `rx` low 40 bit times, then release. Then send 0x3C.
  - Response: one `frame_err` pulse, `rx_data` keeps its prior value, exactly one `rx_done_tick` with `rx_data`=0x3C.
- Back-to-back:
  - Stimulus: 0x00 then 0xFF with no idle gap between stop and start bits.
  - Response: two `rx_done_tick` pulses carrying 0x00 then 0xFF.
- Reset mid-frame:
  - Stimulus: assert `reset` during data bit 3 of 0x81, release, then send 0x7E.
  - Response: all outputs 0 during reset, no strobe for 0x81, `rx_data`=0x7E.
- Tick jitter tolerance:
  - Stimulus: `s_tick` period alternating 3 and 5 clk. Send 0xC3.
  - Response: `rx_data`=0xC3 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling driven by an external one-clock tick.
// Reports each good byte with a done strobe; bad stop bits raise frame_err instead.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int MAXT = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_STOP = CW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_sh;
  logic [1:0]      r_sync;
  logic            w_rx_s;

  assign w_rx_s = r_sync[1];

  // Synchronizer resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_n          <= '0;
      r_sh         <= '0;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_cnt == C_HALF) begin
              if (!w_rx_s) begin
                r_cnt   <= '0;
                r_n     <= '0;
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_cnt == C_FULL) begin
              r_cnt <= '0;
              r_sh  <= {w_rx_s, r_sh[DBIT-1:1]};
              if (r_n == N_LAST) r_state <= STOP;
              else               r_n     <= r_n + NW'(1);
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets a following start bit be caught with no gap.
          if (s_tick) begin
            if (r_cnt == C_STOP) begin
              if (w_rx_s) begin
                rx_data      <= r_sh;
                rx_done_tick <= 1'b1;
                r_state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= WAIT_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected events, a monitor
// pops and compares on every strobe.
module tb_uart_rx;
  localparam int BIT = 64;  // clk per bit at 4 clk per tick (average)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       frame_err;

  uart_rx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_last = 8'h00;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       jitter  = 1'b0;

  // Tick source: every 4 clk, or alternating 3/5 clk when jitter is set.
  initial begin
    logic alt;
    int   p;
    alt = 1'b0;
    forever begin
      p = jitter ? (alt ? 5 : 3) : 4;
      repeat (p - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
      alt = ~alt;
    end
  end

  // Monitor: pop and compare whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (reset) begin
      exp_last = 8'h00;
    end else begin
      if (rx_done_tick && frame_err) begin
        n_tests++;
        n_fail++;
        $display("FAIL both_strobes: done=%0b ferr=%0b, required not both high", rx_done_tick, frame_err);
      end
      if (rx_done_tick) begin
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: rx_data=%02h, required no strobe", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err || rx_data !== e.data) begin
            n_fail++;
            $display("FAIL done_data: got done data=%02h, required %s %02h",
                     rx_data, e.is_err ? "frame_err for" : "done with", e.data);
          end else begin
            $display("[TB] rx byte %02h ok", rx_data);
          end
          if (!e.is_err) exp_last = e.data;
        end
      end else if (frame_err) begin
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ferr: rx_data=%02h, required no strobe", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err || rx_data !== exp_last) begin
            n_fail++;
            $display("FAIL ferr_event: got frame_err rx_data=%02h, required %s, rx_data=%02h",
                     rx_data, e.is_err ? "frame_err" : "done", exp_last);
          end else begin
            $display("[TB] frame error ok, rx_data held %02h", rx_data);
          end
        end
      end else if (rx_data !== exp_last) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_data_hold: rx_data=%02h, required %02h", rx_data, exp_last);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    wait_clk(nb * BIT);
  endtask

  // Sends a full frame; the expected event is queued before the first bit goes out.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    ev_t e;
    e.is_err = ~stop_bit;
    e.data   = d;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
    rx = stop_bit;
    wait_clk(BIT);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (rx_data !== 8'h00 || rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: data=%02h done=%0b ferr=%0b, required 00/0/0",
               name, rx_data, rx_done_tick, frame_err);
    end else begin
      $display("[TB] %s outputs zero ok", name);
    end
  endtask

  initial begin
    int budget;
    logic [7:0] d;

    reset = 1'b1;
    wait_clk(5);
    @(negedge clk);
    check_zero("reset_state");
    wait_clk(1);
    reset = 1'b0;
    idle_bits(1);

    // Basic byte
    send_frame(8'hA5, 1'b1);
    idle_bits(2);

    // False start: low for 3 ticks only
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    idle_bits(2);
    $display("[TB] false start issued");

    // Framing error with a long break, then a good byte
    send_frame(8'h5A, 1'b0);
    rx = 1'b0;
    wait_clk(40 * BIT);
    idle_bits(2);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);

    // Back-to-back with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);

    // Reset in the middle of data bit 3 of 0x81
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h81 >> i);
      wait_clk(BIT);
    end
    rx = 1'b0;
    wait_clk(BIT / 2);
    #2 reset = 1'b1;
    @(negedge clk);
    check_zero("reset_midframe");
    wait_clk(4);
    rx = 1'b1;
    @(negedge clk);
    check_zero("reset_hold");
    wait_clk(1);
    reset = 1'b0;
    idle_bits(1);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);

    // Tick jitter
    jitter = 1'b1;
    send_frame(8'hC3, 1'b1);
    idle_bits(1);

    // Randomized frames, tick modes, stop errors and gaps
    for (int k = 0; k < 24; k++) begin
      jitter = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        send_frame(d, 1'b0);
        idle_bits(1 + $urandom_range(0, 1));
      end else begin
        send_frame(d, 1'b1);
        if ($urandom_range(0, 2) != 0) idle_bits($urandom_range(0, 2));
      end
    end
    idle_bits(2);

    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      wait_clk(1);
      budget++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
